// File: rtl/mac_norm_stage_p.sv
// rtl/mac_norm_stage_p.sv - final MAC stage: partial-sum adder tree plus sign/mantissa/exponent normalise
// Optional feature macro: MAC_NORM_ROUND_EN (round-to-nearest-even of the mantissa; truncation otherwise)
module mac_norm_stage_p #(
  parameter int NUM_PSUM  = 2,
  parameter int PSUM_W    = 19,
  parameter int NORM_W    = 11,
  parameter int EXP_W     = 6,
  parameter int REF_POS   = 16,
  parameter int MEXP_W    = 6,
  parameter int QF_W      = 5,
  parameter int TREE_PIPE = 0
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic                       i_flush,
  input  logic [NUM_PSUM*PSUM_W-1:0] i_psum,
  input  logic [MEXP_W-1:0]          i_max_exp,
  input  logic [QF_W-1:0]            i_Q_frac,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic                       o_sgn,
  output logic                       o_zero,
  output logic [NORM_W-1:0]          o_norm,
  output logic [EXP_W-1:0]           o_exp_shift,
  output logic [MEXP_W-1:0]          o_max_exp,
  output logic [QF_W-1:0]            o_Q_frac
);

  localparam int LVL   = $clog2(NUM_PSUM);
  localparam int SUM_W = PSUM_W + LVL;
  localparam int P_W   = $clog2(SUM_W);
  localparam int EXT_W = SUM_W + NORM_W;

  // Number of live operands at a given tree level (level 0 = input lanes).
  function automatic int lvl_cnt(input int l);
    return (NUM_PSUM + (1 << l) - 1) >> l;
  endfunction

  logic                 en;
  logic                 in_vld_q;
  logic [NUM_PSUM*PSUM_W-1:0] in_psum_q;
  logic [MEXP_W-1:0]    in_mexp_q;
  logic [QF_W-1:0]      in_qf_q;

  logic                 out_vld_q;
  logic                 out_sgn_q;
  logic                 out_zero_q;
  logic [NORM_W-1:0]    out_norm_q;
  logic [EXP_W-1:0]     out_shf_q;
  logic [MEXP_W-1:0]    out_mexp_q;
  logic [QF_W-1:0]      out_qf_q;

  // Single global enable: the whole pipe freezes while the output beat is refused.
  assign en      = ~(out_vld_q & ~i_ready);
  assign o_ready = en;

  // Input register: captures lanes and sideband on every enabled edge; flush kills the valid only.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      in_vld_q  <= 1'b0;
      in_psum_q <= '0;
      in_mexp_q <= '0;
      in_qf_q   <= '0;
    end else begin
      if (i_flush)  in_vld_q <= 1'b0;
      else if (en)  in_vld_q <= i_valid;
      if (en) begin
        in_psum_q <= i_psum;
        in_mexp_q <= i_max_exp;
        in_qf_q   <= i_Q_frac;
      end
    end
  end

  for (genvar l = 0; l <= LVL; l++) begin : g_lvl
    localparam int CUR = lvl_cnt(l);
    logic [SUM_W-1:0]  v [CUR];
    logic              vld;
    logic [MEXP_W-1:0] mexp;
    logic [QF_W-1:0]   qf;

    if (l == 0) begin : g_leaf
      for (genvar k = 0; k < CUR; k++) begin : g_ext
        assign v[k] = {{LVL{in_psum_q[k*PSUM_W+PSUM_W-1]}}, in_psum_q[k*PSUM_W +: PSUM_W]};
      end
      assign vld  = in_vld_q;
      assign mexp = in_mexp_q;
      assign qf   = in_qf_q;
    end else begin : g_node
      localparam int PREV = lvl_cnt(l - 1);
      logic [SUM_W-1:0] s [CUR];

      for (genvar j = 0; j < CUR; j++) begin : g_add
        if (2*j + 1 < PREV) begin : g_pair
          assign s[j] = g_lvl[l-1].v[2*j] + g_lvl[l-1].v[2*j+1];
        end else begin : g_pass
          assign s[j] = g_lvl[l-1].v[2*j];
        end
      end

      if (TREE_PIPE != 0) begin : g_pipe
        logic [SUM_W-1:0]  r [CUR];
        logic              r_vld;
        logic [MEXP_W-1:0] r_mexp;
        logic [QF_W-1:0]   r_qf;

        // Tree level register: advances with the global enable, sideband kept beside its sums.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
          if (!i_rst_n) begin
            for (int i = 0; i < CUR; i++) r[i] <= '0;
            r_vld  <= 1'b0;
            r_mexp <= '0;
            r_qf   <= '0;
          end else begin
            if (i_flush)  r_vld <= 1'b0;
            else if (en)  r_vld <= g_lvl[l-1].vld;
            if (en) begin
              for (int i = 0; i < CUR; i++) r[i] <= s[i];
              r_mexp <= g_lvl[l-1].mexp;
              r_qf   <= g_lvl[l-1].qf;
            end
          end
        end

        assign v    = r;
        assign vld  = r_vld;
        assign mexp = r_mexp;
        assign qf   = r_qf;
      end else begin : g_comb
        assign v    = s;
        assign vld  = g_lvl[l-1].vld;
        assign mexp = g_lvl[l-1].mexp;
        assign qf   = g_lvl[l-1].qf;
      end
    end
  end

  logic [SUM_W-1:0]  sum_w;
  logic [SUM_W-1:0]  mag;
  logic              sgn_d;
  logic              zero_d;
  logic [P_W-1:0]    lead_p;
  logic [P_W-1:0]    sh;
  logic [NORM_W-1:0] mant;
  logic [NORM_W-1:0] norm_pre;
  logic [EXP_W-1:0]  shf_raw;
  logic [EXP_W-1:0]  shf_pre;

  assign sum_w  = g_lvl[LVL].v[0];
  assign sgn_d  = sum_w[SUM_W-1];
  // The most negative sum maps to 2^(SUM_W-1), which still fits unsigned in SUM_W bits.
  assign mag    = sgn_d ? (~sum_w + SUM_W'(1)) : sum_w;
  assign zero_d = (mag == '0);

  // Leading-one detector: last hit in an ascending scan is the highest set bit.
  always_comb begin
    lead_p = '0;
    for (int i = 0; i < SUM_W; i++) begin
      if (mag[i]) lead_p = P_W'(i);
    end
  end

  assign sh      = P_W'(SUM_W - 1) - lead_p;
  assign shf_raw = EXP_W'(lead_p) - EXP_W'(REF_POS);

`ifdef MAC_NORM_ROUND_EN
  logic [EXT_W-1:0]  ext_sh;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic [NORM_W:0]   mant_inc;

  // Left-justify mag so the mantissa is the top NORM_W bits and all discarded bits sit below it.
  assign ext_sh   = {mag, {NORM_W{1'b0}}} << sh;
  assign mant     = ext_sh[EXT_W-1 -: NORM_W];
  assign guard    = ext_sh[SUM_W-1];
  assign sticky   = |ext_sh[SUM_W-2:0];
  assign round_up = guard & (sticky | mant[0]);
  assign mant_inc = {1'b0, mant} + {{NORM_W{1'b0}}, round_up};
  // A carry out of the mantissa renormalises to 1.000... with the exponent bumped by one.
  assign norm_pre = mant_inc[NORM_W] ? {1'b1, {(NORM_W-1){1'b0}}} : mant_inc[NORM_W-1:0];
  assign shf_pre  = shf_raw + {{(EXP_W-1){1'b0}}, mant_inc[NORM_W]};
`else
  assign mant     = NORM_W'(({mag, {NORM_W{1'b0}}} << sh) >> SUM_W);
  assign norm_pre = mant;
  assign shf_pre  = shf_raw;
`endif

  // Output register: normalised result plus sideband, forced clean for a zero sum.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_vld_q  <= 1'b0;
      out_sgn_q  <= 1'b0;
      out_zero_q <= 1'b0;
      out_norm_q <= '0;
      out_shf_q  <= '0;
      out_mexp_q <= '0;
      out_qf_q   <= '0;
    end else begin
      if (i_flush)  out_vld_q <= 1'b0;
      else if (en)  out_vld_q <= g_lvl[LVL].vld;
      if (en) begin
        out_sgn_q  <= sgn_d;
        out_zero_q <= zero_d;
        out_norm_q <= zero_d ? '0 : norm_pre;
        out_shf_q  <= zero_d ? '0 : shf_pre;
        out_mexp_q <= g_lvl[LVL].mexp;
        out_qf_q   <= g_lvl[LVL].qf;
      end
    end
  end

  assign o_valid     = out_vld_q;
  assign o_sgn       = out_sgn_q;
  assign o_zero      = out_zero_q;
  assign o_norm      = out_norm_q;
  assign o_exp_shift = out_shf_q;
  assign o_max_exp   = out_mexp_q;
  assign o_Q_frac    = out_qf_q;

endmodule
